obi_uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter holding register (THR) between NumReq byte-stream requesters, e.g. core console, debug monitor and DMA log.
- Grants the THR to one requester at a time, with round-robin fairness at packet granularity.
- Writes bytes only when the transmitter reports THR empty, and paces writes so that the LSR status lag cannot cause an overrun.
- Sits between the requester streams and the UART register write path, in parallel with the OBI THR write, and is muxed in front of it.

---
 rtl/obi_uart_pkg.sv | 14 +
 rtl/obi_uart_rr_pick.sv | 37 +++
 rtl/obi_uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_obi_uart_tx_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/obi_uart_pkg.sv
// obi_uart_pkg: shared types and constants for the OBI UART block.
// Holds the THR arbiter state encoding and its default write holdoff.
package obi_uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SEND,
    ARB_HOLD
  } arb_state_e;

  // Cycles after a THR write before the LSR THR-empty flag is trusted again.
  localparam int unsigned ArbDefaultHoldoff = 2;

endpackage

// File: rtl/obi_uart_rr_pick.sv
// obi_uart_rr_pick: combinational round-robin priority picker.
// Ports:
//   req  - request vector (N bits)
//   ptr  - index with highest priority; the scan goes upward and wraps
//   gnt  - one-hot grant (zero when req is zero)
//   idx  - binary index of the granted bit (0 when req is zero)
// Used for the TX requesters; the RX side can reuse it for interrupt sources.
module obi_uart_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx
);

  int j;

  // Scan from the farthest position back to ptr so the last hit, which
  // overwrites earlier ones, is the closest to ptr.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= int'(N)) j = j - int'(N);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/obi_uart_tx_arbiter.sv
// obi_uart_tx_arbiter: shares the UART THR between NumReq byte streams.
// Round-robin at packet granularity, paced writes (Holdoff cycles after each
// THR write before thr_empty_i is believed), optional burst limit and lock
// timeout.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   req_valid_i/data/last - per-requester byte stream (requester k at [8k+7:8k])
//   req_ready_o           - byte accepted (one-hot or zero)
//   thr_empty_i           - LSR THR-empty flag
//   thr_write_o/data_o    - single-cycle THR write strobe and byte
//   grant_o               - current owner (one-hot or zero)
//   busy_o                - arbiter not idle
//   timeout_o             - one-cycle pulse when a lock is revoked by timeout
module obi_uart_tx_arbiter
  import obi_uart_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned MaxBurst    = 16,
  parameter int unsigned Holdoff     = ArbDefaultHoldoff,
  parameter int unsigned LockTimeout = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  logic [NumReq*8-1:0] req_data_i,
  input  logic [NumReq-1:0]   req_last_i,
  output logic [NumReq-1:0]   req_ready_o,
  input  logic                thr_empty_i,
  output logic                thr_write_o,
  output logic [7:0]          thr_data_o,
  output logic [NumReq-1:0]   grant_o,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned BurstW = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;
  localparam int unsigned IdleW  = (LockTimeout > 0) ? $clog2(LockTimeout + 1) : 1;
  localparam int unsigned HoldW  = $clog2(Holdoff + 1);
  localparam logic [BurstW-1:0] BurstSat = '1;

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   gidx_q, gidx_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              last_q, last_d;
  logic              release_now;

  logic [NumReq-1:0][7:0] req_data;
  logic [NumReq-1:0]      pick_gnt;
  logic [IdxW-1:0]        pick_idx;

  assign req_data = req_data_i;

  obi_uart_rr_pick #(
    .N    (NumReq),
    .IdxW (IdxW)
  ) u_pick (
    .req (req_valid_i),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      burst_q  <= '0;
      hold_q   <= '0;
      idle_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      hold_q   <= hold_d;
      idle_q   <= idle_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    burst_d     = burst_q;
    hold_d      = hold_q;
    idle_d      = idle_q;
    last_d      = last_q;
    release_now = 1'b0;
    req_ready_o = '0;
    thr_write_o = 1'b0;
    thr_data_o  = '0;
    timeout_o   = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (|req_valid_i) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          burst_d = '0;
          idle_d  = '0;
          state_d = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (req_valid_i[gidx_q] && thr_empty_i) begin
          thr_write_o = 1'b1;
          thr_data_o  = req_data[gidx_q];
          req_ready_o = grant_q;
          last_d      = req_last_i[gidx_q];
          if (burst_q != BurstSat) burst_d = burst_q + 1'b1;
          idle_d      = '0;
          hold_d      = HoldW'(Holdoff - 1);
          state_d     = ARB_HOLD;
        end else if (!req_valid_i[gidx_q] && LockTimeout != 0) begin
          // Granted requester went quiet mid-packet: revoke after LockTimeout
          // idle SEND cycles so it cannot starve the others.
          if (idle_q == IdleW'(LockTimeout - 1)) begin
            timeout_o   = 1'b1;
            release_now = 1'b1;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
      end
      ARB_HOLD: begin
        // LSR lags the write; wait before sampling thr_empty_i again.
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (last_q || (MaxBurst != 0 && burst_q == BurstW'(MaxBurst))) begin
          release_now = 1'b1;
        end else begin
          state_d = ARB_SEND;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (release_now) begin
      rr_ptr_d = (gidx_q == IdxW'(NumReq - 1)) ? '0 : gidx_q + 1'b1;
      grant_d  = '0;
      state_d  = ARB_IDLE;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_obi_uart_tx_arbiter.sv
// Directed bench for obi_uart_tx_arbiter (NumReq=4, MaxBurst=4, Holdoff=2,
// LockTimeout=8). Inputs change 1 time unit after the rising edge; outputs
// are sampled 2 units after it, plus invariant checks on every falling edge.
module tb_obi_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   valid = '0;
  logic [N-1:0]   last = '0;
  logic [N*8-1:0] data = '0;
  logic           thr_empty = 1'b1;
  logic [N-1:0]   ready, grant;
  logic           thr_write, busy, timeout;
  logic [7:0]     thr_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  obi_uart_tx_arbiter #(
    .NumReq(N), .MaxBurst(4), .Holdoff(2), .LockTimeout(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid), .req_data_i(data), .req_last_i(last),
    .req_ready_o(ready), .thr_empty_i(thr_empty),
    .thr_write_o(thr_write), .thr_data_o(thr_data),
    .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    valid[k]       = v;
    data[k*8 +: 8] = d;
    last[k]        = l;
  endtask

  // Wait (bounded) for a THR write; check latency in cycles from now, byte,
  // owner and ready.
  task automatic wait_wr(input string tag, input int exp_n, input logic [7:0] d,
                         input logic [N-1:0] g);
    int n = 0;
    #1;
    while (!thr_write && n < 30) begin
      tick();
      #1;
      n++;
    end
    chk({tag, "_wr"},  32'(thr_write), 32'd1);
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_dat"}, 32'(thr_data), 32'(d));
    chk({tag, "_gnt"}, 32'(grant), 32'(g));
    chk({tag, "_rdy"}, 32'(ready), 32'(g));
  endtask

  always @(negedge clk) begin
    chk("inv_rdy",    32'((ready & ~grant) == '0 && (ready == '0 || thr_write)), 32'd1);
    chk("inv_onehot", 32'($onehot0(grant)), 32'd1);
    chk("inv_empty",  32'(!thr_write || thr_empty), 32'd1);
  end

  initial begin
    int n;
    // reset
    tick(); tick(); #1;
    chk("rst_gnt", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr", 32'(thr_write), 32'd0);
    chk("rst_rdy", 32'(ready), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: requester 0, 3-byte packet, writes at t+1, t+4, t+7
    set_req(0, 1'b1, 8'h41, 1'b0);
    wait_wr("t1_b0", 1, 8'h41, 4'b0001);
    tick(); set_req(0, 1'b1, 8'h42, 1'b0);
    wait_wr("t1_b1", 2, 8'h42, 4'b0001);
    tick(); set_req(0, 1'b1, 8'h43, 1'b1);
    wait_wr("t1_b2", 2, 8'h43, 4'b0001);
    tick(); set_req(0, 1'b0, 8'h00, 1'b0);
    #1 chk("t1_hold_gnt", 32'(grant), 32'b0001);
    tick(); tick(); #1;
    chk("t1_rel_gnt", 32'(grant), 32'd0);
    chk("t1_rel_busy", 32'(busy), 32'd0);
    chk("t1_rr_ptr", 32'(dut.rr_ptr_q), 32'd1);

    // 2: requesters 1 and 3, then 1 again: order 1,3,1
    set_req(1, 1'b1, 8'hA1, 1'b1);
    set_req(3, 1'b1, 8'hA3, 1'b1);
    wait_wr("t2_r1", 1, 8'hA1, 4'b0010);
    tick(); set_req(1, 1'b1, 8'hB1, 1'b1);
    wait_wr("t2_r3", 3, 8'hA3, 4'b1000);
    tick(); set_req(3, 1'b0, 8'h00, 1'b0);
    wait_wr("t2_r1b", 3, 8'hB1, 4'b0010);
    tick(); set_req(1, 1'b0, 8'h00, 1'b0);
    tick(); tick(); #1;
    chk("t2_busy", 32'(busy), 32'd0);

    // 3: THR not empty for 20 cycles, write on the rising cycle
    thr_empty = 1'b0;
    set_req(2, 1'b1, 8'hC2, 1'b1);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("t3_nowr", 32'(thr_write), 32'd0);
      chk("t3_noto", 32'(timeout), 32'd0);
      tick();
    end
    thr_empty = 1'b1;
    wait_wr("t3_wr", 0, 8'hC2, 4'b0100);
    chk("t3_noto_wr", 32'(timeout), 32'd0);
    tick(); set_req(2, 1'b0, 8'h00, 1'b0);
    tick(); tick(); #1;
    chk("t3_busy", 32'(busy), 32'd0);

    // 4: burst limit 4: requester 0 streams, 1 waits; 0 resumes after 1
    set_req(0, 1'b1, 8'h50, 1'b0);
    set_req(1, 1'b1, 8'hD1, 1'b1);
    wait_wr("t4_b0", 1, 8'h50, 4'b0001);
    for (int b = 1; b < 4; b++) begin
      tick(); set_req(0, 1'b1, 8'(8'h50 + b), 1'b0);
      wait_wr("t4_bn", 2, 8'(8'h50 + b), 4'b0001);
    end
    tick(); set_req(0, 1'b1, 8'h54, 1'b0);
    wait_wr("t4_r1", 3, 8'hD1, 4'b0010);
    tick(); set_req(1, 1'b0, 8'h00, 1'b0);
    wait_wr("t4_b4", 3, 8'h54, 4'b0001);
    tick(); set_req(0, 1'b1, 8'h55, 1'b1);
    wait_wr("t4_b5", 2, 8'h55, 4'b0001);
    tick(); set_req(0, 1'b0, 8'h00, 1'b0);
    tick(); tick(); #1;
    chk("t4_busy", 32'(busy), 32'd0);

    // 5: lock timeout 8 after requester 2 goes quiet mid-packet
    set_req(2, 1'b1, 8'hE2, 1'b0);
    wait_wr("t5_b0", 1, 8'hE2, 4'b0100);
    tick(); set_req(2, 1'b0, 8'h00, 1'b0);
    n = 0;
    #1;
    while (!timeout && n < 30) begin
      tick();
      #1;
      n++;
    end
    chk("t5_to", 32'(timeout), 32'd1);
    chk("t5_to_lat", n, 32'd9);
    chk("t5_to_gnt", 32'(grant), 32'b0100);
    tick(); #1;
    chk("t5_rel_gnt", 32'(grant), 32'd0);
    chk("t5_rel_busy", 32'(busy), 32'd0);
    chk("t5_rel_to", 32'(timeout), 32'd0);
    set_req(3, 1'b1, 8'hF3, 1'b0);
    wait_wr("t5_next", 1, 8'hF3, 4'b1000);

    // 6: reset in HOLD mid-packet
    tick();
    rst = 1'b1;
    set_req(3, 1'b1, 8'hA7, 1'b1);
    set_req(1, 1'b1, 8'hC1, 1'b1);
    #1 chk("t6_hold_wr", 32'(thr_write), 32'd0);
    tick(); #1;
    chk("t6_rst_gnt", 32'(grant), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_wr", 32'(thr_write), 32'd0);
    chk("t6_rst_rdy", 32'(ready), 32'd0);
    chk("t6_rst_dat", 32'(thr_data), 32'd0);
    tick();
    rst = 1'b0;
    wait_wr("t6_first", 1, 8'hC1, 4'b0010);

    tick();
    valid = '0;
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
